// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan display:
// load-mode encoding and active-low segment patterns ({g,f,e,d,c,b,a}).
package seg_pkg;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// The first bit is consumed on the start edge; done pulses for one cycle with bcd final.
module bin2bcd_seq #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BCD_DIGITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_W-1:0]         bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_DIGITS*4-1:0]   bcd
);

    localparam int unsigned BCD_W = BCD_DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state, state_nx;
    logic [DATA_W-1:0]  bin_q, bin_nx;
    logic [BCD_W-1:0]   bcd_nx, bcd_adj;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               busy_nx, done_nx;

    // Add 3 to every digit of 5 or more ahead of the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nx = state;
        bin_nx   = bin_q;
        bcd_nx   = bcd;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SHIFT;
                    bin_nx   = bin << 1;
                    bcd_nx   = BCD_W'(bin[DATA_W-1]);
                    cnt_nx   = CNT_W'(DATA_W - 1);
                    busy_nx  = 1'b1;
                end
            end
            S_SHIFT: begin
                bin_nx = bin_q << 1;
                bcd_nx = BCD_W'({bcd_adj, bin_q[DATA_W-1]});
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            bin_q <= '0;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            bin_q <= bin_nx;
            bcd   <= bcd_nx;
            cnt   <= cnt_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment display driver: hex or decimal value capture,
// leading-zero blanking and a free-running digit scan.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [DATA_W-1:0]      Value,
    input  logic                   Load,
    input  logic                   Mode,
    input  logic                   BlankLZ,
    output logic                   Busy,
    output logic [NUM_DIGITS-1:0]  en_out,
    output logic [6:0]             out7
);

    localparam int unsigned DISP_W     = NUM_DIGITS * 4;
    localparam int unsigned BCD_DIGITS = (DATA_W * 3) / 10 + 1;
    localparam int unsigned BCD_W      = BCD_DIGITS * 4;
    localparam int unsigned CNT_W      = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DISP_W-1:0]  disp;
    mode_e              mode_q;
    logic               blank_q;
    logic               blank_pend;
    logic [CNT_W-1:0]   refresh_cnt;
    logic [IDX_W-1:0]   idx;

    logic               accept;
    logic               conv_start;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [3:0]         digit;
    logic               lead_zero;
    logic [6:0]         seg;

    assign accept     = Load && !Busy;
    assign conv_start = accept && (Mode == MODE_DEC);

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (Clk),
        .rst   (Reset),
        .start (conv_start),
        .bin   (Value),
        .busy  (Busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Blank flag for a decimal load waits with the result so the old value stays intact.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            disp       <= '0;
            mode_q     <= MODE_HEX;
            blank_q    <= 1'b0;
            blank_pend <= 1'b0;
        end else if (accept) begin
            mode_q     <= mode_e'(Mode);
            blank_pend <= BlankLZ;
            if (Mode == MODE_HEX) begin
                disp    <= DISP_W'(Value);
                blank_q <= BlankLZ;
            end
        end else if (conv_done && mode_q == MODE_DEC) begin
            disp    <= DISP_W'(conv_bcd);
            blank_q <= blank_pend;
        end
    end

    always_comb begin
        digit     = disp[{idx, 2'b00} +: 4];
        lead_zero = (disp >> {idx, 2'b00}) == '0;
        seg       = seg_encode(digit);
        if (blank_q && idx != IDX_W'(0) && lead_zero) begin
            seg = SEG_BLANK;
        end
    end

    // Scan timing and registered digit drive.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
            en_out      <= ~NUM_DIGITS'(1);
            out7        <= SEG_ZERO;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                idx         <= (idx == IDX_W'(NUM_DIGITS - 1)) ? IDX_W'(0) : idx + IDX_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            en_out <= ~(NUM_DIGITS'(1) << idx);
            out7   <= seg;
        end
    end

endmodule
